piso_bit_serializer: RTL and testbench

Parallel-in, serial-out front end for the bit-serial sequence detectors. Accepts W-bit words over a valid/ready handshake and presents them one bit per clock on `x_out`, qualified by `x_valid`, for direct connection to a detector's `x` input. A one-word holding buffer lets back-to-back words stream with no idle bit between them.

---
 rtl/piso_bit_serializer.sv | 139 +++++++++++++
 tb/tb_piso_bit_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// rtl/piso_bit_serializer.sv - parallel-in, serial-out bit serializer with a one-word holding buffer
//
// Converts W-bit words taken over a valid/ready handshake into a one-bit-per-clock
// stream for a bit-serial detector. A holding register lets the next word be taken
// while the current one shifts, so consecutive words leave with no idle bit.
//
// Build option: define PISO_LSB_FIRST_EN for LSB-first serialization (default MSB first).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   [W-1:0] parallel word, sampled on accept
//   in_valid   in   upstream offers a word
//   in_ready   out  a word can be taken this cycle (holding buffer empty)
//   x_out      out  current serial bit, 0 when x_valid is low
//   x_valid    out  x_out carries a data bit
//   word_done  out  x_out carries the last bit of a word
//   busy       out  a word is shifting or held

module piso_bit_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         x_out,
  output logic         x_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef PISO_LSB_FIRST_EN
  localparam int OUT_IDX = 0;
`else
  localparam int OUT_IDX = W - 1;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           x_out_q, x_out_d;
  logic           word_done_q, word_done_d;
  logic           accept;

  // Moves the next bit to be sent into the output position.
  function automatic logic [W-1:0] shift_word(input logic [W-1:0] w);
`ifdef PISO_LSB_FIRST_EN
    return {1'b0, w[W-1:1]};
`else
    return {w[W-2:0], 1'b0};
`endif
  endfunction

  // in_ready is purely a function of registered state.
  assign accept = in_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sreg_d = shift_word(sreg_q);
          cnt_d  = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Held word follows the last bit directly; accept is blocked this cycle.
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word offered during the last bit bypasses the holding buffer.
          sreg_d = in_data;
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next state so they line up with the new sreg.
    x_out_d     = (state_d == SHIFT) ? sreg_d[OUT_IDX] : 1'b0;
    word_done_d = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_out_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      x_out_q     <= x_out_d;
      word_done_q <= word_done_d;
    end
  end

  assign in_ready  = ~hold_full_q;
  assign x_valid   = (state_q == SHIFT);
  assign x_out     = x_out_q;
  assign word_done = word_done_q;
  assign busy      = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb/tb_piso_bit_serializer.sv - scoreboard bench for piso_bit_serializer

module tb_piso_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         x_out;
  logic         x_valid;
  logic         word_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Each entry is {last_bit_of_word, data_bit}, in the order bits must leave the DUT.
  logic [1:0] exp_q[$];

  piso_bit_serializer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word contributes W bits in the configured order, last one flagged.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
`ifdef PISO_LSB_FIRST_EN
      exp_q.push_back({(i == W - 1), w[i]});
`else
      exp_q.push_back({(i == W - 1), w[W-1-i]});
`endif
    end
  endtask

  // Monitor: whenever pending bits exist the stream must be active and contiguous;
  // the holding buffer is full exactly when more than one word is pending.
  always @(negedge clk) begin
    if (!rst) begin
      check("x_valid", x_valid, exp_q.size() > 0);
      check("in_ready", in_ready, exp_q.size() <= W);
      check("busy", busy, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("x_out", x_out, exp_q[0][0]);
        check("word_done", word_done, exp_q[0][1]);
        void'(exp_q.pop_front());
      end else begin
        check("x_out_idle", x_out, 1'b0);
        check("word_done_idle", word_done, 1'b0);
      end
    end
  end

  // Offer a word and keep in_valid high until it is accepted; leaves in_valid high.
  task automatic offer(input logic [W-1:0] w);
    int waited;
    waited   = 0;
    in_data  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (in_ready) break;
      waited++;
      if (waited > 4 * W) begin
        checks++;
        errors++;
        $display("FAIL offer_timeout: got in_ready 0 for %0d cycles required acceptance within %0d", waited, 4 * W);
        in_valid = 1'b0;
        return;
      end
    end
    push_word(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_x_out", x_out, 1'b0);
    check("rst_word_done", word_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word.
    offer(8'hD0);
    idle(12);
    // Back-to-back pair with in_valid held.
    offer(8'hD0);
    offer(8'hB4);
    idle(20);
    // Word offered in the last-bit cycle with hold empty.
    offer(8'hA5);
    idle(W - 1);
    offer(8'h3C);
    idle(12);
    // Three words continuously: third stalls until the first word's last bit.
    offer(8'h0B);
    offer(8'h81);
    offer(8'h7E);
    idle(30);

    // Reset mid-word with the holding buffer full.
    offer(8'h3C);
    offer(8'h96);
    in_valid = 1'b0;
    check("pre_rst_in_ready", in_ready, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_x_valid", x_valid, 1'b0);
    check("async_rst_x_out", x_out, 1'b0);
    check("async_rst_word_done", word_done, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_x_valid", x_valid, 1'b0);
    @(posedge clk);
    #1;

    // Randomized traffic with random gaps, including gaps ending on last-bit cycles.
    for (int n = 0; n < 300; n++) begin
      offer(W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, W + 2));
    end
    idle(3 * W);
    check("drained", exp_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
